common_bus_arbiter: RTL

- Round-robin arbiter and sequencer for the shared snooping cache bus (Data/Address/READrWRITE/BusRd/BusUpd/Shared).
- Grants exclusive ownership of the bus to one of NUM_REQ cache controllers at a time.
- Holds the grant until the owner signals completion, then inserts one release/turnaround cycle in which the bus data driver is tristated.
- Sits beside the bus interface; cache controllers request through it before driving any bus signal.

---
 rtl/CachePackage.sv | 13 +
 rtl/rr_priority_pick.sv | 28 ++
 rtl/common_bus_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/CachePackage.sv
// Shared types and constants for the snooping cache bus: arbiter FSM states
// and the default number of cache controllers on the bus.
package CachePackage;

  localparam int NUM_CACHES = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN     = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: scans req starting one past ptr (wrapping)
// and reports the first asserted requester.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    winner
);

  // The pointer itself is scanned last, so the previous owner sits at the tail.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    valid  = 1'b0;
    winner = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/common_bus_arbiter.sv
// Round-robin owner arbiter for the shared snooping cache bus, with a one-cycle
// release/turnaround slot after each tenure. Optional hold limit: BUS_TIMEOUT_EN.
module common_bus_arbiter
  import CachePackage::*;
#(
  parameter int NUM_REQ  = NUM_CACHES,
  parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int MAX_HOLD = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_rw,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               bus_busy,
  output logic               read_not_write,
  output logic               bus_release
`ifdef BUS_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  if (NUM_REQ < 1 || NUM_REQ > 16 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("common_bus_arbiter: NUM_REQ must be 1..16 and MAX_HOLD >= 1");
  end

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               rnw_q, rnw_d;
  logic               release_q, release_d;
  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic               owner_done;
  logic               tenure_end;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  // A dropped request from the owner ends the tenure just like done.
  assign owner_done = done[gnt_id_q] || !req[gnt_id_q];

`ifdef BUS_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;
  logic              hold_expired;

  assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign tenure_end   = owner_done || hold_expired;

  always_comb begin
    hold_d    = hold_q;
    timeout_d = timeout_q;
    if (state_q != ARB_OWN) begin
      hold_d = '0;
    end else if (!tenure_end) begin
      hold_d = hold_q + HOLD_W'(1);
    end else if (!owner_done) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign tenure_end = owner_done;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    rnw_d     = rnw_q;
    release_d = 1'b0;
    case (state_q)
      ARB_IDLE, ARB_RELEASE: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
        if (pick_valid) begin
          gnt_d[pick_id] = 1'b1;
          gnt_id_d       = pick_id;
          ptr_d          = pick_id;
          rnw_d          = req_rw[pick_id];
          state_d        = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (tenure_end) begin
          gnt_d     = '0;
          release_d = 1'b1;
          state_d   = ARB_RELEASE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      rnw_q     <= 1'b1;
      release_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      rnw_q     <= rnw_d;
      release_q <= release_d;
    end
  end

  assign gnt            = gnt_q;
  assign gnt_id         = gnt_id_q;
  assign bus_busy       = |gnt_q;
  assign read_not_write = rnw_q;
  assign bus_release    = release_q;

endmodule
